// File: rtl/player_ctrl.sv
// Purpose : Galaxian player ship controller - key decode, clamped horizontal motion,
//           rate-limited fire requests and the life/explosion/respawn/game-over FSM.
// Latency : all outputs registered; a key or hit sampled on an edge is reflected on that same edge.
// Backpressure: none; fire_req is a one-frame pulse that the missile block must accept when issued.
//
// Ports:
//   frame_clk   frame clock, every state change happens on its rising edge
//   Reset_n     synchronous active-low reset
//   keycodes    NUM_KEYS 8-bit keycode slots, 8'h00 = empty slot
//   hit         player struck this frame (sampled once per edge)
//   PlayerX/Y/S ship centre X, fixed centre Y, fixed half-extent
//   fire_req    one-frame missile request, shot_x is the launch X while it is high
//   lives_left  remaining lives
//   alive/exploding/game_over  state decode (all low while respawning)
module player_ctrl #(
    parameter int NUM_KEYS       = 2,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 639,
    parameter int SHIP_SIZE      = 40,
    parameter int START_X        = 320,
    parameter int START_Y        = 440,
    parameter int STEP           = 4,
    parameter int FIRE_COOLDOWN  = 16,
    parameter int LIVES          = 3,
    parameter int EXPLODE_FRAMES = 32,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic                  frame_clk,
    input  logic                  Reset_n,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic                  hit,
    output logic [9:0]            PlayerX,
    output logic [9:0]            PlayerY,
    output logic [9:0]            PlayerS,
    output logic                  fire_req,
    output logic [9:0]            shot_x,
    output logic [3:0]            lives_left,
    output logic                  alive,
    output logic                  exploding,
    output logic                  game_over
);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_EXPLODING = 2'd1,
        ST_RESPAWN   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    // Keycodes of interest
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    // Clamp limits for the ship centre so the sprite never leaves the screen
    localparam logic [9:0]  X_LO       = 10'(X_MIN + SHIP_SIZE);
    localparam logic [9:0]  X_LO_STEP  = 10'(X_MIN + SHIP_SIZE + STEP);
    localparam logic [9:0]  X_HI       = 10'(X_MAX - SHIP_SIZE);
    localparam logic [10:0] X_HI_EXT   = 11'(X_MAX - SHIP_SIZE);
    localparam logic [9:0]  STEP_10    = 10'(STEP);
    localparam logic [10:0] STEP_11    = 11'(STEP);
    localparam logic [9:0]  START_X_10 = 10'(START_X);

    localparam logic [7:0] COOLDOWN_INIT = 8'(FIRE_COOLDOWN);
    localparam logic [7:0] EXPLODE_INIT  = 8'(EXPLODE_FRAMES - 1);
    localparam logic [7:0] RESPAWN_INIT  = 8'(RESPAWN_FRAMES - 1);
    localparam logic [3:0] LIVES_INIT    = 4'(LIVES);

    // State registers
    state_t     state_q,    state_d;
    logic [9:0] x_q,        x_d;
    logic [3:0] lives_q,    lives_d;
    logic [7:0] cooldown_q, cooldown_d;
    logic [7:0] timer_q,    timer_d;
    logic       fire_req_q, fire_req_d;
    logic [9:0] shot_x_q,   shot_x_d;

    // Key decode: any slot may carry any code, duplicates are harmless
    logic key_left, key_right, key_fire;

    always_comb begin
        key_left  = 1'b0;
        key_right = 1'b0;
        key_fire  = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycodes[8*i +: 8] == KEY_A || keycodes[8*i +: 8] == KEY_LEFT) begin
                key_left = 1'b1;
            end
            if (keycodes[8*i +: 8] == KEY_D || keycodes[8*i +: 8] == KEY_RIGHT) begin
                key_right = 1'b1;
            end
            if (keycodes[8*i +: 8] == KEY_SPACE) begin
                key_fire = 1'b1;
            end
        end
    end

    // Candidate positions for a left or right step, clamped at the edges.
    // The left test compares before subtracting so it can never underflow;
    // the right sum carries an extra bit so it can never wrap.
    logic [9:0]  x_left;
    logic [10:0] x_sum_right;
    logic [9:0]  x_right;

    always_comb begin
        x_left      = (x_q <= X_LO_STEP) ? X_LO : (x_q - STEP_10);
        x_sum_right = {1'b0, x_q} + STEP_11;
        x_right     = (x_sum_right >= X_HI_EXT) ? X_HI : x_sum_right[9:0];
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        lives_d    = lives_q;
        timer_d    = timer_q;
        fire_req_d = 1'b0;
        shot_x_d   = shot_x_q;
        // Cooldown drains in every state unless a fire reloads it below
        cooldown_d = (cooldown_q != 8'd0) ? (cooldown_q - 8'd1) : 8'd0;

        case (state_q)
            ST_ALIVE: begin
                if (hit) begin
                    // Hit wins over fire and movement on this frame
                    state_d = ST_EXPLODING;
                    lives_d = (lives_q != 4'd0) ? (lives_q - 4'd1) : 4'd0;
                    timer_d = EXPLODE_INIT;
                end else begin
                    if (key_fire && cooldown_q == 8'd0) begin
                        fire_req_d = 1'b1;
                        shot_x_d   = x_q;           // launch from the pre-move position
                        cooldown_d = COOLDOWN_INIT;
                    end
                    if (key_left && !key_right) begin
                        x_d = x_left;
                    end else if (key_right && !key_left) begin
                        x_d = x_right;
                    end
                end
            end

            ST_EXPLODING: begin
                if (timer_q == 8'd0) begin
                    if (lives_q == 4'd0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_RESPAWN;
                        timer_d = RESPAWN_INIT;
                        x_d     = START_X_10;
                    end
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            ST_RESPAWN: begin
                if (timer_q == 8'd0) begin
                    state_d    = ST_ALIVE;
                    cooldown_d = 8'd0;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end

            ST_GAME_OVER: begin
                // Sticky until reset; position frozen, keys and hits ignored
                state_d = ST_GAME_OVER;
            end

            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    // Single state register block; reset beats every other input
    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q    <= ST_ALIVE;
            x_q        <= START_X_10;
            lives_q    <= LIVES_INIT;
            cooldown_q <= 8'd0;
            timer_q    <= 8'd0;
            fire_req_q <= 1'b0;
            shot_x_q   <= 10'd0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            lives_q    <= lives_d;
            cooldown_q <= cooldown_d;
            timer_q    <= timer_d;
            fire_req_q <= fire_req_d;
            shot_x_q   <= shot_x_d;
        end
    end

    // Outputs
    assign PlayerX    = x_q;
    assign PlayerY    = 10'(START_Y);
    assign PlayerS    = 10'(SHIP_SIZE);
    assign fire_req   = fire_req_q;
    assign shot_x     = shot_x_q;
    assign lives_left = lives_q;
    assign alive      = (state_q == ST_ALIVE);
    assign exploding  = (state_q == ST_EXPLODING);
    assign game_over  = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_player_ctrl.sv
// Purpose : self-checking bench for player_ctrl against a frame-level behavioural model.
// Latency : outputs sampled 1 ns after each rising frame_clk edge.
// Backpressure: not applicable.
module tb_player_ctrl;

    localparam int NUM_KEYS = 2;
    localparam int X_LO     = 40;
    localparam int X_HI     = 599;
    localparam int START_X  = 320;
    localparam int START_Y  = 440;
    localparam int SHIP     = 40;
    localparam int STEP     = 4;
    localparam int FIRE_CD  = 16;
    localparam int LIVES    = 3;
    localparam int EXPL_N   = 32;
    localparam int RESP_N   = 60;

    // Model phases (bench-local naming)
    localparam int PH_PLAY = 0;
    localparam int PH_BOOM = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_DEAD = 3;

    logic        frame_clk = 1'b0;
    logic        Reset_n   = 1'b0;
    logic [15:0] keycodes  = 16'h0000;
    logic        hit       = 1'b0;
    logic [9:0]  PlayerX, PlayerY, PlayerS, shot_x;
    logic        fire_req, alive, exploding, game_over;
    logic [3:0]  lives_left;

    player_ctrl dut (
        .frame_clk  (frame_clk),
        .Reset_n    (Reset_n),
        .keycodes   (keycodes),
        .hit        (hit),
        .PlayerX    (PlayerX),
        .PlayerY    (PlayerY),
        .PlayerS    (PlayerS),
        .fire_req   (fire_req),
        .shot_x     (shot_x),
        .lives_left (lives_left),
        .alive      (alive),
        .exploding  (exploding),
        .game_over  (game_over)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_phase;
    int m_x;
    int m_lives;
    int m_cd;
    int m_frames_left;
    int m_fire;
    int m_shot;

    function automatic void decode(input logic [15:0] k, output bit l, output bit r, output bit f);
        logic [7:0] s;
        l = 0; r = 0; f = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            s = k[8*i +: 8];
            if (s == 8'h04 || s == 8'h50) l = 1;
            if (s == 8'h07 || s == 8'h4F) r = 1;
            if (s == 8'h2C) f = 1;
        end
    endfunction

    // One frame of game rules, applied to the inputs present at the edge
    task automatic model_edge();
        bit l, r, f;
        decode(keycodes, l, r, f);
        if (!Reset_n) begin
            m_phase = PH_PLAY; m_x = START_X; m_lives = LIVES;
            m_cd = 0; m_frames_left = 0; m_fire = 0; m_shot = 0;
            return;
        end
        m_fire = 0;
        case (m_phase)
            PH_PLAY: begin
                if (hit) begin
                    m_lives = m_lives - 1;
                    m_phase = PH_BOOM;
                    m_frames_left = EXPL_N;
                    if (m_cd > 0) m_cd--;
                end else begin
                    if (f && m_cd == 0) begin
                        m_fire = 1; m_shot = m_x; m_cd = FIRE_CD;
                    end else if (m_cd > 0) begin
                        m_cd--;
                    end
                    if (l && !r) m_x = (m_x - STEP < X_LO) ? X_LO : m_x - STEP;
                    if (r && !l) m_x = (m_x + STEP > X_HI) ? X_HI : m_x + STEP;
                end
            end
            PH_BOOM: begin
                if (m_cd > 0) m_cd--;
                m_frames_left--;
                if (m_frames_left == 0) begin
                    if (m_lives == 0) begin
                        m_phase = PH_DEAD;
                    end else begin
                        m_phase = PH_WAIT; m_frames_left = RESP_N; m_x = START_X;
                    end
                end
            end
            PH_WAIT: begin
                if (m_cd > 0) m_cd--;
                m_frames_left--;
                if (m_frames_left == 0) begin
                    m_phase = PH_PLAY; m_cd = 0;
                end
            end
            default: begin
                if (m_cd > 0) m_cd--;
            end
        endcase
    endtask

    // Apply current inputs over one edge, advance the model, then settle for sampling
    task automatic tick();
        @(posedge frame_clk);
        model_edge();
        #1;
    endtask

    function automatic logic [46:0] dut_vec();
        return {PlayerX, PlayerY, PlayerS, fire_req, shot_x, lives_left, alive, exploding, game_over};
    endfunction

    function automatic logic [46:0] model_vec();
        return {10'(m_x), 10'(START_Y), 10'(SHIP), 1'(m_fire), 10'(m_shot), 4'(m_lives),
                m_phase == PH_PLAY, m_phase == PH_BOOM, m_phase == PH_DEAD};
    endfunction

    task automatic do_reset();
        Reset_n = 1'b0; hit = 1'b0; keycodes = 16'h0000;
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        keycodes = 16'h2C4F; hit = 1'b1; Reset_n = 1'b0;
        tick();
        n_checks++;
        if ({PlayerX, lives_left, alive, exploding, game_over, fire_req, shot_x, PlayerY, PlayerS}
            !== {10'd320, 4'd3, 3'b100, 1'b0, 10'd0, 10'd440, 10'd40}) begin
            $display("FAIL reset_values: got X=%0d lives=%0d a/e/g=%b%b%b fire=%b shot=%0d Y=%0d S=%0d",
                     PlayerX, lives_left, alive, exploding, game_over, fire_req, shot_x, PlayerY, PlayerS);
        end else n_pass++;
        Reset_n = 1'b1; hit = 1'b0; keycodes = 16'h0000;
    endtask

    task automatic test_move_left();
        do_reset();
        keycodes = 16'h0050;
        for (int i = 0; i < 80; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL move_left frame %0d: got X=%0d alive=%b, expected X=%0d", i, PlayerX, alive, m_x);
            end else n_pass++;
            if (i == 68 || i == 69 || i == 79) begin
                n_checks++;
                if (PlayerX !== ((i == 68) ? 10'd44 : 10'd40)) begin
                    $display("FAIL left_clamp frame %0d: got %0d expected %0d", i, PlayerX, (i == 68) ? 44 : 40);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_move_right();
        do_reset();
        keycodes = 16'h4F00;
        for (int i = 0; i < 75; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL move_right frame %0d: got X=%0d expected X=%0d", i, PlayerX, m_x);
            end else n_pass++;
            if (i == 68 || i == 69 || i == 74) begin
                n_checks++;
                if (PlayerX !== ((i == 68) ? 10'd596 : 10'd599)) begin
                    $display("FAIL right_clamp frame %0d: got %0d expected %0d", i, PlayerX, (i == 68) ? 596 : 599);
                end else n_pass++;
            end
        end
        keycodes = 16'h0407;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (PlayerX !== 10'd599) begin
                $display("FAIL both_dirs frame %0d: got %0d expected 599", i, PlayerX);
            end else n_pass++;
        end
    endtask

    task automatic test_fire();
        do_reset();
        keycodes = 16'h002C;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_checks++;
            if (fire_req !== (i % 17 == 0) || shot_x !== 10'd320 && i != 0 || dut_vec() !== model_vec()) begin
                $display("FAIL fire_rate frame %0d: got fire=%b shot=%0d expected fire=%b shot=320",
                         i, fire_req, shot_x, (i % 17 == 0));
            end else n_pass++;
        end
        do_reset();
        keycodes = 16'h2C4F;
        tick();
        n_checks++;
        if ({fire_req, shot_x, PlayerX} !== {1'b1, 10'd320, 10'd324}) begin
            $display("FAIL fire_premove: got fire=%b shot=%0d X=%0d expected 1/320/324", fire_req, shot_x, PlayerX);
        end else n_pass++;
    endtask

    task automatic test_hit_respawn();
        int n_boom, n_wait, guard;
        do_reset();
        keycodes = 16'h0050;
        for (int i = 0; i < 5; i++) tick();
        keycodes = 16'h2C50; hit = 1'b1;
        tick();
        hit = 1'b0;
        n_checks++;
        if ({fire_req, exploding, lives_left, PlayerX} !== {1'b0, 1'b1, 4'd2, 10'd300}) begin
            $display("FAIL hit_entry: got fire=%b expl=%b lives=%0d X=%0d expected 0/1/2/300",
                     fire_req, exploding, lives_left, PlayerX);
        end else n_pass++;
        n_boom = 1; n_wait = 0; guard = 0;
        while (exploding === 1'b1 && guard < 200) begin
            hit = (n_boom == 10);
            tick();
            if (exploding === 1'b1) n_boom++;
            guard++;
        end
        while (alive === 1'b0 && exploding === 1'b0 && game_over === 1'b0 && guard < 200) begin
            n_wait++;
            n_checks++;
            if (PlayerX !== 10'd320 || dut_vec() !== model_vec()) begin
                $display("FAIL respawn_pos: got X=%0d expected 320", PlayerX);
            end else n_pass++;
            hit = (n_wait == 20);
            tick();
            guard++;
        end
        hit = 1'b0;
        n_checks++;
        if ({n_boom, n_wait, alive, lives_left} !== {32'd32, 32'd60, 1'b1, 4'd2}) begin
            $display("FAIL explode_respawn_len: got boom=%0d wait=%0d alive=%b lives=%0d expected 32/60/1/2",
                     n_boom, n_wait, alive, lives_left);
        end else n_pass++;
    endtask

    task automatic test_game_over();
        logic [9:0] frozen_x;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
            for (int i = 0; i < EXPL_N + RESP_N + 2; i++) begin
                keycodes = {8'h50, 8'h2C};
                hit = ($urandom_range(0, 7) == 0);
                if (k == 2 && i >= EXPL_N) hit = 1'b0;
                tick();
                n_checks++;
                if (dut_vec() !== model_vec()) begin
                    $display("FAIL life_cycle %0d frame %0d: got %h expected %h", k, i, dut_vec(), model_vec());
                end else n_pass++;
                if (k < 2 && alive === 1'b1) break;
            end
            hit = 1'b0;
        end
        n_checks++;
        if ({lives_left, game_over, alive, exploding} !== {4'd0, 3'b100}) begin
            $display("FAIL game_over_entry: got lives=%0d go=%b alive=%b expl=%b expected 0/1/0/0",
                     lives_left, game_over, alive, exploding);
        end else n_pass++;
        frozen_x = PlayerX;
        for (int i = 0; i < 20; i++) begin
            keycodes = {8'h4F, 8'h2C};
            hit = $urandom_range(0, 1);
            tick();
            n_checks++;
            if ({PlayerX, game_over, fire_req, lives_left} !== {frozen_x, 1'b1, 1'b0, 4'd0}) begin
                $display("FAIL game_over_sticky frame %0d: got X=%0d go=%b fire=%b lives=%0d",
                         i, PlayerX, game_over, fire_req, lives_left);
            end else n_pass++;
        end
        hit = 1'b0;
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        n_checks++;
        if ({lives_left, PlayerX, alive, game_over} !== {4'd3, 10'd320, 1'b1, 1'b0}) begin
            $display("FAIL game_over_reset: got lives=%0d X=%0d alive=%b go=%b", lives_left, PlayerX, alive, game_over);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        keycodes = 16'h002C;
        tick();                         // fire loads cooldown
        hit = 1'b1;
        tick();
        hit = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        n_checks++;
        if (exploding !== 1'b1) begin
            $display("FAIL reset_mid_setup: got exploding=%b expected 1", exploding);
        end else n_pass++;
        Reset_n = 1'b0; hit = 1'b1;
        tick();
        Reset_n = 1'b1; hit = 1'b0;
        n_checks++;
        if ({alive, lives_left, fire_req, PlayerX} !== {1'b1, 4'd3, 1'b0, 10'd320}) begin
            $display("FAIL reset_mid: got alive=%b lives=%0d fire=%b X=%0d expected 1/3/0/320",
                     alive, lives_left, fire_req, PlayerX);
        end else n_pass++;
        tick();                         // cooldown cleared: fire is accepted at once
        n_checks++;
        if (fire_req !== 1'b1 || dut_vec() !== model_vec()) begin
            $display("FAIL reset_mid_cooldown: got fire=%b expected 1", fire_req);
        end else n_pass++;
        keycodes = 16'h0000;
    endtask

    task automatic test_random();
        logic [7:0] pool [8];
        pool = '{8'h00, 8'h04, 8'h50, 8'h07, 8'h4F, 8'h2C, 8'h11, 8'hFF};
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            keycodes = {pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)]};
            hit      = ($urandom_range(0, 39) == 0);
            Reset_n  = ($urandom_range(0, 299) != 0);
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL random frame %0d: got %h expected %h", i, dut_vec(), model_vec());
            end else n_pass++;
        end
        Reset_n = 1'b1; hit = 1'b0; keycodes = 16'h0000;
    endtask

    initial begin
        m_phase = PH_PLAY; m_x = START_X; m_lives = LIVES;
        m_cd = 0; m_frames_left = 0; m_fire = 0; m_shot = 0;
        #2;
        test_reset();
        test_move_left();
        test_move_right();
        test_fire();
        test_hit_respawn();
        test_game_over();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
